gpio_bank_mmio: RTL
===================

Name: gpio_bank_mmio

Overview:
Parametrised successor to the single-port GPIO controller on the MIPS RAM data bus. It provides NUM_PORTS memory-mapped GPIO ports, each with output, input, interrupt-enable, interrupt-polarity and interrupt-pending registers. Inputs pass through a 2-flop synchroniser and an edge detector, and pending interrupts are combined into one irq line. The block sits beside the data-bus demux: hit steers sw data here instead of to MemoryUnit, and lw data is returned through rdata/rvalid.

Parameters:
DATA_WIDTH, 32, bus data width.
ADDR_WIDTH, 32, bus address width.
PORT_WIDTH, 8, pins per port; legal range 1..DATA_WIDTH.
NUM_PORTS, 4, number of ports; legal range 1..8.
BASE_ADDR, 32'h1001_0040, byte address of port 0 register 0.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
addr  in  ADDR_WIDTH  byte address (ALUOut).
wdata  in  DATA_WIDTH  store data.
we  in  1  write strobe, one cycle per sw.
re  in  1  read strobe, one cycle per lw.
hit  out  1  combinational; addr falls inside this block's window.
rdata  out  DATA_WIDTH  registered read data.
rvalid  out  1  one-cycle pulse, the cycle after an accepted re.
align_err  out  1  registered one-cycle pulse on a misaligned we or re inside the window.
gpio_in  in  NUM_PORTS*PORT_WIDTH  asynchronous pins; port p occupies bits [p*PORT_WIDTH +: PORT_WIDTH].
gpio_out  out  NUM_PORTS*PORT_WIDTH  output latches, same packing as gpio_in.
irq  out  1  registered OR over all ports of (PEND & EN).

Behaviour:
- Address decode:
  - off = addr - BASE_ADDR.
  - hit = (addr >= BASE_ADDR) && (off < NUM_PORTS*32).
  - port = off[7:5]; reg = off[4:2].
  - Access is misaligned when off[1:0] != 0.
- Register map, per port, at 32-byte stride:
  - 0x00 OUT: read/write.
  - 0x04 IN: read-only, returns the synchronised value.
  - 0x08 EN: read/write.
  - 0x0C POL: read/write; bit = 0 selects rising edge, 1 selects falling edge.
  - 0x10 PEND: read; write-1-to-clear.
  - 0x14–0x1C: reserved; reads return 0, writes are ignored.
- Width rules: writes use wdata[PORT_WIDTH-1:0] and ignore the upper bits. Reads zero-extend to DATA_WIDTH.
- Accepted access: hit && aligned.
  - we: updates the register on the same clock edge.
  - re: rdata is loaded on that edge and rvalid = 1 for that one cycle. The read latency is therefore 1 cycle.
  - rdata holds its value until the next accepted read.
- we and re asserted together: the write takes effect, and the read returns the pre-write value.
- Misaligned or !hit access: no register changes and no rvalid.
  - align_err pulses only when hit && misaligned.
- Input path: gpio_in → sync1 → sync2 (IN) → prev.
  - Rising event: sync2 & ~prev. Falling event: ~sync2 & prev.
  - A selected event sets the matching PEND bit regardless of EN.
  - EN gates only irq.
  - Latency from a pin change to PEND set is 3 clk edges; irq asserts 1 cycle after that.
- Set and W1C clear on the same bit in the same cycle: set wins, and PEND stays 1.
- Changing POL can create a spurious event; software clears PEND after any POL write. No hardware masking is applied.
- Reset, asynchronous and active-low:
  - Cleared to 0: OUT, EN, POL, PEND, sync1, sync2, prev, rdata, rvalid, align_err, irq.
  - gpio_out therefore reads 0.
  - Reset asserted mid-access aborts the access; there is no pending state to recover.
- Fixed FSM: none beyond the registers; the block is a pipelined register bank.

Decomposition:
- Shared package gpio_bank_pkg holds:
  - register offsets: OFF_OUT, OFF_IN, OFF_EN, OFF_POL, OFF_PEND;
  - PORT_STRIDE = 32;
  - the default BASE_ADDR;
  - a reg_sel_t enum for the 3-bit register index.
- One sub-module, gpio_port_slice, is instantiated NUM_PORTS times. Each slice contains:
  - the synchroniser, edge detect and PEND logic;
  - the OUT, EN and POL registers;
  - a local irq term.
- The top level holds the decode, the read mux, rdata/rvalid/align_err and the irq OR.

Test Plan:
- Write then read back: sw 0xFFFF_FFA5 to BASE+0x20 (port1 OUT) → gpio_out[15:8] = 0xA5 the next cycle. lw from the same address → rvalid one cycle later with rdata = 0x0000_00A5.
- Rising-edge irq: write EN port0 = 0x01, then drive gpio_in[0] 0→1 → PEND0 bit0 = 1 after 3 edges and irq = 1 one cycle later. Write 0x01 to BASE+0x10 → PEND = 0 and irq drops.
- Falling polarity without enable: write POL port2 = 0x80 and leave EN = 0, then drive gpio_in[23] 1→0 → PEND2 = 0x80 and irq stays 0. Then write EN port2 = 0x80 → irq = 1.
- Set versus clear collision: align a W1C of bit0 with the edge-detect event on bit0 in the same cycle → PEND bit0 reads 1.
- Decode boundaries:
  - lw at BASE+0x80 with NUM_PORTS = 4 → hit = 0, no rvalid.
  - sw at BASE+0x22 → align_err pulse and OUT unchanged.
  - lw at BASE+0x18 → rdata = 0.
- Async reset mid-operation: with OUT = 0xFF and PEND = 0x0F, assert reset low between clock edges → gpio_out, irq and rdata = 0 immediately. After release, an lw of port0 PEND returns 0.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: register map constants and register-index enum shared by the GPIO bank.
`default_nettype none

package gpio_bank_pkg;

    localparam logic [4:0]  OFF_OUT           = 5'h00;
    localparam logic [4:0]  OFF_IN            = 5'h04;
    localparam logic [4:0]  OFF_EN            = 5'h08;
    localparam logic [4:0]  OFF_POL           = 5'h0C;
    localparam logic [4:0]  OFF_PEND          = 5'h10;
    localparam int          PORT_STRIDE       = 32;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0040;

    typedef enum logic [2:0] {
        REG_OUT  = OFF_OUT[4:2],
        REG_IN   = OFF_IN[4:2],
        REG_EN   = OFF_EN[4:2],
        REG_POL  = OFF_POL[4:2],
        REG_PEND = OFF_PEND[4:2],
        REG_RSV5 = 3'd5,
        REG_RSV6 = 3'd6,
        REG_RSV7 = 3'd7
    } reg_sel_t;

endpackage

`default_nettype wire

// File: rtl/gpio_port_slice.sv
// gpio_port_slice: one GPIO port -- OUT/EN/POL registers, 2-flop input sync,
// edge detect and sticky PEND with write-1-to-clear.
`default_nettype none

module gpio_port_slice
    import gpio_bank_pkg::*;
#(
    parameter int PORT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PORT_WIDTH-1:0] wdata_i,
    input  logic                  wr_out_i,
    input  logic                  wr_en_i,
    input  logic                  wr_pol_i,
    input  logic                  clr_pend_i,
    input  logic [PORT_WIDTH-1:0] pin_i,
    output logic [PORT_WIDTH-1:0] out_o,
    output logic [PORT_WIDTH-1:0] in_o,
    output logic [PORT_WIDTH-1:0] en_o,
    output logic [PORT_WIDTH-1:0] pol_o,
    output logic [PORT_WIDTH-1:0] pend_o,
    output logic                  irq_o
);

    logic [PORT_WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [PORT_WIDTH-1:0] out_q, en_q, pol_q, pend_q, pend_d;
    logic [PORT_WIDTH-1:0] event_d;

    // New events are ORed in after the clear so a same-cycle set beats W1C.
    always_comb begin
        event_d = ((sync2_q & ~prev_q) & ~pol_q) | ((~sync2_q & prev_q) & pol_q);
        pend_d  = pend_q;
        if (clr_pend_i) begin
            pend_d = pend_q & ~wdata_i;
        end
        pend_d = pend_d | event_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            out_q   <= '0;
            en_q    <= '0;
            pol_q   <= '0;
            pend_q  <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
            if (wr_out_i) out_q <= wdata_i;
            if (wr_en_i)  en_q  <= wdata_i;
            if (wr_pol_i) pol_q <= wdata_i;
        end
    end

    assign out_o  = out_q;
    assign in_o   = sync2_q;
    assign en_o   = en_q;
    assign pol_o  = pol_q;
    assign pend_o = pend_q;
    assign irq_o  = |(pend_q & en_q);

endmodule

`default_nettype wire

// File: rtl/gpio_bank_mmio.sv
// gpio_bank_mmio: NUM_PORTS memory-mapped GPIO ports on the data bus with
// address decode, registered read-back, alignment error and a combined irq.
`default_nettype none

module gpio_bank_mmio
    import gpio_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    PORT_WIDTH = 8,
    parameter int                    NUM_PORTS  = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEFAULT_BASE_ADDR)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic                            we,
    input  logic                            re,
    output logic                            hit,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            rvalid,
    output logic                            align_err,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_out,
    output logic                            irq
);

    localparam logic [ADDR_WIDTH-1:0] WINDOW = ADDR_WIDTH'(NUM_PORTS * PORT_STRIDE);

    logic [ADDR_WIDTH-1:0] off;
    logic                  misaligned, acc_we, acc_re;
    logic [2:0]            port_idx;
    reg_sel_t              reg_sel;

    // Sized for the maximum of 8 ports so the 3-bit port index never overruns.
    logic [PORT_WIDTH-1:0] out_a  [8];
    logic [PORT_WIDTH-1:0] in_a   [8];
    logic [PORT_WIDTH-1:0] en_a   [8];
    logic [PORT_WIDTH-1:0] pol_a  [8];
    logic [PORT_WIDTH-1:0] pend_a [8];
    logic [NUM_PORTS-1:0]  irq_vec;

    logic [PORT_WIDTH-1:0] rd_sel;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q, align_err_q, irq_q;

    assign off        = addr - BASE_ADDR;
    assign hit        = (addr >= BASE_ADDR) && (off < WINDOW);
    assign misaligned = |off[1:0];
    assign port_idx   = off[7:5];
    assign reg_sel    = reg_sel_t'(off[4:2]);
    assign acc_we     = we && hit && !misaligned;
    assign acc_re     = re && hit && !misaligned;

    for (genvar p = 0; p < 8; p++) begin : g_port
        if (p < NUM_PORTS) begin : g_slice
            logic sel;
            assign sel = acc_we && (port_idx == 3'(p));

            gpio_port_slice #(
                .PORT_WIDTH (PORT_WIDTH)
            ) u_slice (
                .clk        (clk),
                .rst_n      (reset),
                .wdata_i    (wdata[PORT_WIDTH-1:0]),
                .wr_out_i   (sel && (reg_sel == REG_OUT)),
                .wr_en_i    (sel && (reg_sel == REG_EN)),
                .wr_pol_i   (sel && (reg_sel == REG_POL)),
                .clr_pend_i (sel && (reg_sel == REG_PEND)),
                .pin_i      (gpio_in[p*PORT_WIDTH +: PORT_WIDTH]),
                .out_o      (out_a[p]),
                .in_o       (in_a[p]),
                .en_o       (en_a[p]),
                .pol_o      (pol_a[p]),
                .pend_o     (pend_a[p]),
                .irq_o      (irq_vec[p])
            );

            assign gpio_out[p*PORT_WIDTH +: PORT_WIDTH] = out_a[p];
        end else begin : g_pad
            assign out_a[p]  = '0;
            assign in_a[p]   = '0;
            assign en_a[p]   = '0;
            assign pol_a[p]  = '0;
            assign pend_a[p] = '0;
        end
    end

    always_comb begin
        rd_sel = '0;
        case (reg_sel)
            REG_OUT:  rd_sel = out_a[port_idx];
            REG_IN:   rd_sel = in_a[port_idx];
            REG_EN:   rd_sel = en_a[port_idx];
            REG_POL:  rd_sel = pol_a[port_idx];
            REG_PEND: rd_sel = pend_a[port_idx];
            default:  rd_sel = '0;
        endcase
        rdata_d                 = '0;
        rdata_d[PORT_WIDTH-1:0] = rd_sel;
    end

    // rdata samples the pre-edge register value, so a combined we+re returns old data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            align_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (acc_re) rdata_q <= rdata_d;
            rvalid_q    <= acc_re;
            align_err_q <= hit && misaligned && (we || re);
            irq_q       <= |irq_vec;
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign align_err = align_err_q;
    assign irq       = irq_q;

endmodule

`default_nettype wire
